// File: rtl/seq_mult_arbiter_pkg.sv
// Shared types and widths for the seq_mult request arbiter.
// State encodings match the multiplier's defs header so traces line up.
package seq_mult_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_BUSY   = 2'd2,
    S_RESP   = 2'd3
  } arb_state_t;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  // Busy counter must be able to hold TIMEOUT itself on the final BUSY edge.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/seq_mult_arbiter_if.sv
// Requester-side and multiplier-side signals of the seq_mult arbiter.
// slave = arbiter view, master = environment (requesters + multiplier) view.
interface seq_mult_arbiter_if #(
  parameter int N_REQ = 4
);
  import seq_mult_arbiter_pkg::*;

  logic [N_REQ-1:0]      req;
  logic [OP_W*N_REQ-1:0] req_dataa;
  logic [OP_W*N_REQ-1:0] req_datab;
  logic [N_REQ-1:0]      gnt;
  logic [N_REQ-1:0]      resp_valid;
  logic                  resp_err;
  logic [PROD_W-1:0]     resp_product;
  logic                  busy;
  logic [OP_W-1:0]       mul_dataa;
  logic [OP_W-1:0]       mul_datab;
  logic                  mul_start;
  logic                  mul_done;
  logic [PROD_W-1:0]     mul_product;

  modport slave (
    input  req, req_dataa, req_datab, mul_done, mul_product,
    output gnt, resp_valid, resp_err, resp_product, busy,
           mul_dataa, mul_datab, mul_start
  );

  modport master (
    output req, req_dataa, req_datab, mul_done, mul_product,
    input  gnt, resp_valid, resp_err, resp_product, busy,
           mul_dataa, mul_datab, mul_start
  );

endinterface

// File: rtl/seq_mult_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
// ptr itself is scanned last, so the previous winner has lowest priority.
module seq_mult_arbiter_rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     any
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/seq_mult_arbiter.sv
// Shares one sequential 8x8 multiplier between N_REQ requesters with
// round-robin arbitration, a stale-done guard window and a watchdog timeout.
module seq_mult_arbiter
  import seq_mult_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int GUARD   = 1,
  parameter int TIMEOUT = 15
) (
  input logic               clk,
  input logic               reset_a,
  seq_mult_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = cnt_width(TIMEOUT);

  arb_state_t        state, state_nxt;
  logic [IDX_W-1:0]  ptr;
  logic [N_REQ-1:0]  win_oh;
  logic [CNT_W-1:0]  cnt;

  logic [N_REQ-1:0]  pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic              pick_en;
  logic              done_hit;
  logic              to_hit;
  logic [OP_W-1:0]   pick_a;
  logic [OP_W-1:0]   pick_b;

  logic [N_REQ-1:0]  gnt_r;
  logic [N_REQ-1:0]  resp_valid_r;
  logic              resp_err_r;
  logic [PROD_W-1:0] resp_product_r;
  logic              busy_r;
  logic [OP_W-1:0]   mul_a_r;
  logic [OP_W-1:0]   mul_b_r;
  logic              mul_start_r;

  seq_mult_arbiter_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .grant (pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    pick_a = '0;
    pick_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_a = bus.req_dataa[i*OP_W +: OP_W];
        pick_b = bus.req_datab[i*OP_W +: OP_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // RESP arbitrates like IDLE so a pending request launches back-to-back.
  always_comb begin
    state_nxt = state;
    pick_en   = 1'b0;
    done_hit  = 1'b0;
    to_hit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_any) begin
          pick_en   = 1'b1;
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: state_nxt = S_BUSY;
      S_BUSY: begin
        if (bus.mul_done && (cnt >= CNT_W'(GUARD))) begin
          done_hit  = 1'b1;
          state_nxt = S_RESP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          to_hit    = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (pick_any) begin
          pick_en   = 1'b1;
          state_nxt = S_LAUNCH;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      ptr            <= IDX_W'(N_REQ - 1);
      win_oh         <= '0;
      cnt            <= '0;
      gnt_r          <= '0;
      resp_valid_r   <= '0;
      resp_err_r     <= 1'b0;
      resp_product_r <= '0;
      busy_r         <= 1'b0;
      mul_a_r        <= '0;
      mul_b_r        <= '0;
      mul_start_r    <= 1'b0;
    end else begin
      gnt_r        <= '0;
      mul_start_r  <= 1'b0;
      resp_valid_r <= '0;
      busy_r       <= (state_nxt != S_IDLE);
      cnt          <= (state == S_BUSY) ? cnt + 1'b1 : '0;
      if (pick_en) begin
        ptr         <= pick_idx;
        win_oh      <= pick_oh;
        mul_a_r     <= pick_a;
        mul_b_r     <= pick_b;
        gnt_r       <= pick_oh;
        mul_start_r <= 1'b1;
      end
      if (done_hit) begin
        resp_valid_r   <= win_oh;
        resp_err_r     <= 1'b0;
        resp_product_r <= bus.mul_product;
      end else if (to_hit) begin
        resp_valid_r   <= win_oh;
        resp_err_r     <= 1'b1;
        resp_product_r <= '0;
      end
    end
  end

  assign bus.gnt          = gnt_r;
  assign bus.resp_valid   = resp_valid_r;
  assign bus.resp_err     = resp_err_r;
  assign bus.resp_product = resp_product_r;
  assign bus.busy         = busy_r;
  assign bus.mul_dataa    = mul_a_r;
  assign bus.mul_datab    = mul_b_r;
  assign bus.mul_start    = mul_start_r;

endmodule

// File: tb/tb_seq_mult_arbiter.sv
// Scoreboard bench for seq_mult_arbiter with a behavioural seq_mult model
// (done after LAT edges, optional stale done and never-done modes).
module tb_seq_mult_arbiter;
  import seq_mult_arbiter_pkg::*;

  localparam int N_REQ   = 4;
  localparam int GUARD   = 1;
  localparam int TIMEOUT = 15;
  localparam int LAT     = 4;
  localparam int D_OK    = LAT + 2;
  localparam int D_TO    = TIMEOUT + 1;

  typedef struct { int idx; logic err; logic [15:0] prod; int delta; } exp_t;
  typedef struct { int idx; logic [7:0] a; logic [7:0] b; } gnt_t;

  logic clk = 1'b0;
  logic reset_a = 1'b1;
  seq_mult_arbiter_if #(.N_REQ(N_REQ)) bus ();

  seq_mult_arbiter #(.N_REQ(N_REQ), .GUARD(GUARD), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_a (reset_a),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  gnt_t gnt_q[$];
  int   total = 0;
  int   bad = 0;
  int   drv_to = 0;
  logic expect_zero = 1'b1;
  logic expect_busy = 1'b0;
  logic stale_mode = 1'b0;
  logic never_done = 1'b0;
  logic [N_REQ-1:0] hold = '0;

  // Multiplier model
  int          m_lat = 0;
  logic        m_done = 1'b0;
  logic        m_clr = 1'b0;
  logic [15:0] m_pend = '0;
  logic [15:0] m_prod = '0;

  always @(posedge clk) begin
    m_clr <= 1'b0;
    if (bus.mul_start) begin
      m_lat  <= LAT;
      m_pend <= 16'(bus.mul_dataa) * 16'(bus.mul_datab);
      if (stale_mode) m_clr  <= 1'b1;
      else            m_done <= 1'b0;
    end else begin
      if (m_clr) m_done <= 1'b0;
      if (m_lat != 0) begin
        m_lat <= m_lat - 1;
        if (m_lat == 1 && !never_done) begin
          m_done <= 1'b1;
          m_prod <= m_pend;
        end
      end
    end
  end

  assign bus.mul_done    = m_done;
  assign bus.mul_product = m_prod;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req_v);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents gnt or resp_valid.
  initial begin
    int   cyc = 0;
    int   gnt_cyc = 0;
    int   stall = 0;
    int   drv_seen = 0;
    exp_t e;
    gnt_t g;
    forever begin
      @(negedge clk);
      cyc++;
      if (drv_to != drv_seen) begin
        chk("wait_budget", 64'(drv_to), 64'(drv_seen));
        drv_seen = drv_to;
      end
      if (expect_zero) begin
        chk("reset_outputs", {bus.gnt, bus.resp_valid, bus.resp_err, bus.resp_product,
                              bus.busy, bus.mul_dataa, bus.mul_datab, bus.mul_start}, 64'd0);
        stall = 0;
      end else begin
        chk("gnt_onehot0", 64'($onehot0(bus.gnt)), 64'd1);
        chk("resp_onehot0", 64'($onehot0(bus.resp_valid)), 64'd1);
        if (expect_busy) chk("busy_b2b", 64'(bus.busy), 64'd1);
        stall++;
        if (bus.gnt != '0) begin
          stall = 0;
          gnt_cyc = cyc;
          if (gnt_q.size() == 0) begin
            chk("gnt_unexpected", 64'(bus.gnt), 64'd0);
          end else begin
            g = gnt_q.pop_front();
            chk("gnt", 64'(bus.gnt), 64'(1) << g.idx);
            chk("mul_start", 64'(bus.mul_start), 64'd1);
            chk("mul_operands", {bus.mul_dataa, bus.mul_datab}, {g.a, g.b});
          end
        end
        if (bus.resp_valid != '0) begin
          stall = 0;
          if (exp_q.size() == 0) begin
            chk("resp_unexpected", 64'(bus.resp_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("resp_valid", 64'(bus.resp_valid), 64'(1) << e.idx);
            chk("resp_err", 64'(bus.resp_err), 64'(e.err));
            chk("resp_product", 64'(bus.resp_product), 64'(e.prod));
            chk("resp_latency", 64'(cyc - gnt_cyc), 64'(e.delta));
          end
        end
        if (exp_q.size() == 0 && gnt_q.size() == 0) stall = 0;
        if (stall > 40) begin
          chk("dut_stalled", 64'(exp_q.size() + gnt_q.size()), 64'd0);
          exp_q.delete();
          gnt_q.delete();
          stall = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++)
      if (bus.gnt[i] && !hold[i]) bus.req[i] = 1'b0;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.req_dataa[8*i +: 8] = a;
    bus.req_datab[8*i +: 8] = b;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || gnt_q.size() != 0 || bus.busy) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) drv_to++;
  endtask

  initial begin
    int n;
    bus.req       = '0;
    bus.req_dataa = '0;
    bus.req_datab = '0;
    reset_a       = 1'b1;
    expect_zero   = 1'b1;
    repeat (2) tick();
    reset_a     = 1'b0;
    expect_zero = 1'b0;

    // Single op
    set_op(0, 8'h6E, 8'h0A);
    gnt_q.push_back('{0, 8'h6E, 8'h0A});
    exp_q.push_back('{0, 1'b0, 16'h044C, D_OK});
    bus.req[0] = 1'b1;
    wait_done(100);

    // All four requesting after a fresh reset: 0,1,2,3 back-to-back
    reset_a = 1'b1;
    expect_zero = 1'b1;
    repeat (2) tick();
    reset_a = 1'b0;
    expect_zero = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      set_op(i, 8'(i + 1), 8'd3);
      gnt_q.push_back('{i, 8'(i + 1), 8'd3});
    end
    exp_q.push_back('{0, 1'b0, 16'd3, D_OK});
    exp_q.push_back('{1, 1'b0, 16'd6, D_OK});
    exp_q.push_back('{2, 1'b0, 16'd9, D_OK});
    exp_q.push_back('{3, 1'b0, 16'd12, D_OK});
    bus.req = 4'b1111;
    tick();
    expect_busy = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    expect_busy = 1'b0;
    wait_done(100);

    // Fairness: req[0] held, req[2] joins while 0 is busy -> 0,2,0
    hold[0] = 1'b1;
    set_op(0, 8'd5, 8'd7);
    gnt_q.push_back('{0, 8'd5, 8'd7});
    exp_q.push_back('{0, 1'b0, 16'h0023, D_OK});
    bus.req[0] = 1'b1;
    repeat (3) tick();
    set_op(2, 8'd9, 8'd11);
    gnt_q.push_back('{2, 8'd9, 8'd11});
    exp_q.push_back('{2, 1'b0, 16'h0063, D_OK});
    gnt_q.push_back('{0, 8'd5, 8'd7});
    exp_q.push_back('{0, 1'b0, 16'h0023, D_OK});
    bus.req[2] = 1'b1;
    n = 0;
    while (gnt_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    hold[0] = 1'b0;
    bus.req[0] = 1'b0;
    wait_done(100);

    // Watchdog: multiplier never finishes, then a normal op with max operands
    never_done = 1'b1;
    set_op(1, 8'h12, 8'h34);
    gnt_q.push_back('{1, 8'h12, 8'h34});
    exp_q.push_back('{1, 1'b1, 16'h0000, D_TO});
    bus.req[1] = 1'b1;
    wait_done(100);
    never_done = 1'b0;
    set_op(1, 8'hFF, 8'hFF);
    gnt_q.push_back('{1, 8'hFF, 8'hFF});
    exp_q.push_back('{1, 1'b0, 16'hFE01, D_OK});
    bus.req[1] = 1'b1;
    wait_done(100);

    // Stale done held high into the next op must be masked by the guard
    set_op(3, 8'h20, 8'h08);
    gnt_q.push_back('{3, 8'h20, 8'h08});
    exp_q.push_back('{3, 1'b0, 16'h0100, D_OK});
    bus.req[3] = 1'b1;
    wait_done(100);
    stale_mode = 1'b1;
    set_op(3, 8'h0C, 8'h0D);
    gnt_q.push_back('{3, 8'h0C, 8'h0D});
    exp_q.push_back('{3, 1'b0, 16'h009C, D_OK});
    bus.req[3] = 1'b1;
    wait_done(100);
    stale_mode = 1'b0;

    // Reset mid-BUSY: result discarded, pointer back to N_REQ-1
    set_op(2, 8'd3, 8'd4);
    gnt_q.push_back('{2, 8'd3, 8'd4});
    bus.req[2] = 1'b1;
    repeat (3) tick();
    reset_a = 1'b1;
    expect_zero = 1'b1;
    repeat (2) tick();
    reset_a = 1'b0;
    expect_zero = 1'b0;
    set_op(1, 8'h0B, 8'h0B);
    set_op(3, 8'h80, 8'h02);
    gnt_q.push_back('{1, 8'h0B, 8'h0B});
    gnt_q.push_back('{3, 8'h80, 8'h02});
    exp_q.push_back('{1, 1'b0, 16'h0079, D_OK});
    exp_q.push_back('{3, 1'b0, 16'h0100, D_OK});
    bus.req = 4'b1010;
    wait_done(200);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
